// File: rtl/link_pkg.sv
// Shared types and default widths for the linked-list engine.
package link_pkg;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_NODE_AW     = 8;
    localparam int DEF_TABLE_WIDTH = 3;

    typedef enum logic [1:0] {
        OP_INSERT = 2'b00,
        OP_DELETE = 2'b01,
        OP_CHANGE = 2'b10,
        OP_READ   = 2'b11
    } order_type_e;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WALK,
        ST_MODIFY,
        ST_RESP
    } state_e;

endpackage

// File: rtl/link_node_ram.sv
// Node storage: payload and next-pointer arrays, combinational reads,
// one synchronous write port per array. The next array has two read
// ports so a node and its successor can be resolved in the same cycle.
module link_node_ram
    import link_pkg::*;
#(
    parameter int DW = DEF_DATA_WIDTH,
    parameter int AW = DEF_NODE_AW
) (
    input  logic          clk,
    input  logic [AW-1:0] next_raddr_a,
    output logic [AW-1:0] next_rdata_a,
    input  logic [AW-1:0] next_raddr_b,
    output logic [AW-1:0] next_rdata_b,
    input  logic [AW-1:0] data_raddr,
    output logic [DW-1:0] data_rdata,
    input  logic          next_we,
    input  logic [AW-1:0] next_waddr,
    input  logic [AW-1:0] next_wdata,
    input  logic          data_we,
    input  logic [AW-1:0] data_waddr,
    input  logic [DW-1:0] data_wdata
);

    localparam int DEPTH = 2**AW;

    logic [DW-1:0] data_mem [DEPTH];
    logic [AW-1:0] next_mem [DEPTH];

    assign next_rdata_a = next_mem[next_raddr_a];
    assign next_rdata_b = next_mem[next_raddr_b];
    assign data_rdata   = data_mem[data_raddr];

    // Payload write port
    always_ff @(posedge clk) begin
        if (data_we) data_mem[data_waddr] <= data_wdata;
    end

    // Link write port
    always_ff @(posedge clk) begin
        if (next_we) next_mem[next_waddr] <= next_wdata;
    end

endmodule

// File: rtl/link_engine.sv
// Multi-table singly linked-list engine with a private node pool and free
// list. One positional order in flight; one response per order.
module link_engine
    import link_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int NODE_AW     = DEF_NODE_AW,
    parameter int TABLE_WIDTH = DEF_TABLE_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   order_valid,
    output logic                   order_busy,
    input  logic [1:0]             order_type,
    input  logic [TABLE_WIDTH-1:0] order_table,
    input  logic [NODE_AW:0]       order_node,
    input  logic [DATA_WIDTH-1:0]  order_data,
    output logic                   dout_valid,
    input  logic                   dout_busy,
    output logic [DATA_WIDTH-1:0]  dout_data,
    output logic                   dout_err,
    output logic [NODE_AW:0]       free_count
);

    localparam int NODE_DEPTH = 2**NODE_AW;
    localparam int NUM_TABLES = 2**TABLE_WIDTH;
    localparam int LW         = NODE_AW + 1;
    localparam int SUMW       = NODE_AW + TABLE_WIDTH + 2;

    state_e                               state;
    order_type_e                          o_type;
    logic [TABLE_WIDTH-1:0]               o_table;
    logic [LW-1:0]                        o_pos;
    logic [DATA_WIDTH-1:0]                o_data;
    logic                                 o_err;
    logic [LW-1:0]                        cnt;
    logic [NODE_AW-1:0]                   cur;
    logic [NODE_AW-1:0]                   free_head;
    logic [NODE_AW-1:0]                   init_idx;
    logic [NUM_TABLES-1:0][NODE_AW-1:0]   head;
    logic [NUM_TABLES-1:0][LW-1:0]        len;

    // Second link write of an INSERT/DELETE, retired during RESP because
    // the link array has a single write port.
    logic                                 defer_en;
    logic [NODE_AW-1:0]                   defer_addr;
    logic [NODE_AW-1:0]                   defer_val;

    logic [NODE_AW-1:0]                   next_a, next_b, next_raddr_b;
    logic [NODE_AW-1:0]                   data_raddr, next_waddr, next_wdata, data_waddr;
    logic [DATA_WIDTH-1:0]                data_rd, data_wdata;
    logic                                 next_we, data_we;

    order_type_e                          acc_type;
    logic [LW-1:0]                        acc_len, acc_walk;
    logic                                 acc_err;
    logic                                 pos_zero;
    logic [NODE_AW-1:0]                   after_pred;
    logic [SUMW-1:0]                      node_sum;

    // Node following the predecessor: the DELETE victim or the INSERT successor.
    assign pos_zero     = (o_pos == '0);
    assign after_pred   = pos_zero ? head[o_table] : next_a;
    assign next_raddr_b = (o_type == OP_INSERT) ? free_head : after_pred;
    assign data_raddr   = (o_type == OP_DELETE) ? after_pred : cur;

    link_node_ram #(.DW(DATA_WIDTH), .AW(NODE_AW)) u_ram (
        .clk          (clk),
        .next_raddr_a (cur),
        .next_rdata_a (next_a),
        .next_raddr_b (next_raddr_b),
        .next_rdata_b (next_b),
        .data_raddr   (data_raddr),
        .data_rdata   (data_rd),
        .next_we      (next_we),
        .next_waddr   (next_waddr),
        .next_wdata   (next_wdata),
        .data_we      (data_we),
        .data_waddr   (data_waddr),
        .data_wdata   (data_wdata)
    );

    // Accept-time legality check and walk length for the incoming order
    always_comb begin
        acc_type = order_type_e'(order_type);
        acc_len  = len[order_table];
        acc_err  = (order_node >= acc_len);
        acc_walk = order_node;
        case (acc_type)
            OP_INSERT: begin
                acc_err  = (order_node > acc_len) || (free_count == '0);
                acc_walk = (order_node == '0) ? '0 : order_node - 1'b1;
            end
            OP_DELETE: begin
                acc_walk = (order_node == '0) ? '0 : order_node - 1'b1;
            end
            default: ;
        endcase
    end

    // Storage write steering: init chain, modify-time writes, deferred link
    always_comb begin
        next_we    = 1'b0;
        next_waddr = cur;
        next_wdata = free_head;
        data_we    = 1'b0;
        data_waddr = cur;
        data_wdata = o_data;
        case (state)
            ST_INIT: begin
                next_we    = 1'b1;
                next_waddr = init_idx;
                next_wdata = init_idx + 1'b1;
            end
            ST_MODIFY: begin
                case (o_type)
                    OP_INSERT: begin
                        next_we    = !pos_zero;
                        next_wdata = free_head;
                        data_we    = 1'b1;
                        data_waddr = free_head;
                    end
                    OP_DELETE: begin
                        next_we    = !pos_zero;
                        next_wdata = next_b;
                    end
                    OP_CHANGE: data_we = 1'b1;
                    default: ;
                endcase
            end
            ST_RESP: begin
                next_we    = defer_en;
                next_waddr = defer_addr;
                next_wdata = defer_val;
            end
            default: ;
        endcase
    end

    // Main sequencer: init, accept, walk, modify, respond
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_INIT;
            order_busy <= 1'b1;
            dout_valid <= 1'b0;
            dout_data  <= '0;
            dout_err   <= 1'b0;
            free_count <= '0;
            free_head  <= '0;
            init_idx   <= '0;
            head       <= '0;
            len        <= '0;
            o_type     <= OP_INSERT;
            o_table    <= '0;
            o_pos      <= '0;
            o_data     <= '0;
            o_err      <= 1'b0;
            cnt        <= '0;
            cur        <= '0;
            defer_en   <= 1'b0;
            defer_addr <= '0;
            defer_val  <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_idx <= init_idx + 1'b1;
                    if (&init_idx) begin
                        state      <= ST_IDLE;
                        order_busy <= 1'b0;
                        free_head  <= '0;
                        free_count <= LW'(NODE_DEPTH);
                    end
                end
                ST_IDLE: begin
                    if (order_valid) begin
                        o_type     <= acc_type;
                        o_table    <= order_table;
                        o_pos      <= order_node;
                        o_data     <= order_data;
                        o_err      <= acc_err;
                        cnt        <= acc_walk;
                        cur        <= head[order_table];
                        order_busy <= 1'b1;
                        state      <= ST_WALK;
                    end
                end
                ST_WALK: begin
                    if (o_err) begin
                        dout_valid <= 1'b1;
                        dout_err   <= 1'b1;
                        dout_data  <= '0;
                        state      <= ST_RESP;
                    end else if (cnt == '0) begin
                        state <= ST_MODIFY;
                    end else begin
                        cur <= next_a;
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_MODIFY: begin
                    dout_valid <= 1'b1;
                    dout_err   <= 1'b0;
                    dout_data  <= data_rd;
                    defer_en   <= 1'b0;
                    state      <= ST_RESP;
                    case (o_type)
                        OP_INSERT: begin
                            dout_data  <= '0;
                            if (pos_zero) head[o_table] <= free_head;
                            free_head      <= next_b;
                            free_count     <= free_count - 1'b1;
                            len[o_table]   <= len[o_table] + 1'b1;
                            defer_en       <= 1'b1;
                            defer_addr     <= free_head;
                            defer_val      <= after_pred;
                        end
                        OP_DELETE: begin
                            if (pos_zero) head[o_table] <= next_b;
                            free_head      <= after_pred;
                            free_count     <= free_count + 1'b1;
                            len[o_table]   <= len[o_table] - 1'b1;
                            defer_en       <= 1'b1;
                            defer_addr     <= after_pred;
                            defer_val      <= free_head;
                        end
                        default: ;
                    endcase
                end
                ST_RESP: begin
                    if (!dout_busy) begin
                        dout_valid <= 1'b0;
                        defer_en   <= 1'b0;
                        order_busy <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Node conservation total: free nodes plus all list lengths
    always_comb begin
        node_sum = SUMW'(free_count);
        for (int t = 0; t < NUM_TABLES; t++) node_sum = node_sum + SUMW'(len[t]);
    end

    // Every node is either free or on exactly one list whenever idle
    always_ff @(posedge clk) begin
        if (rst_n && state == ST_IDLE) assert (node_sum == SUMW'(NODE_DEPTH));
    end

endmodule

// File: tb/tb_link_engine.sv
// Directed bench for link_engine with a queue scoreboard and a response monitor.
module tb_link_engine;

    localparam logic [1:0] INS = 2'b00;
    localparam logic [1:0] DEL = 2'b01;
    localparam logic [1:0] CHG = 2'b10;
    localparam logic [1:0] RD  = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        order_valid = 1'b0;
    logic        order_busy;
    logic [1:0]  order_type = 2'b00;
    logic [2:0]  order_table = '0;
    logic [8:0]  order_node = '0;
    logic [15:0] order_data = '0;
    logic        dout_valid;
    logic        dout_busy = 1'b0;
    logic [15:0] dout_data;
    logic        dout_err;
    logic [8:0]  free_count;

    link_engine #(.DATA_WIDTH(16), .NODE_AW(8), .TABLE_WIDTH(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .order_valid (order_valid),
        .order_busy  (order_busy),
        .order_type  (order_type),
        .order_table (order_table),
        .order_node  (order_node),
        .order_data  (order_data),
        .dout_valid  (dout_valid),
        .dout_busy   (dout_busy),
        .dout_data   (dout_data),
        .dout_err    (dout_err),
        .free_count  (free_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] d;
        logic        e;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mq[8][$];
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Drive one order, then queue its expected response and latency.
    task automatic issue(input logic [1:0] ty, input int t, input int pos,
                         input logic [15:0] d, input logic [15:0] ed, input logic ee);
        exp_t e;
        int   n = 0;
        int   w;
        @(negedge clk);
        while (order_busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (order_busy) begin
            fail("issue_wait");
            return;
        end
        order_valid = 1'b1;
        order_type  = ty;
        order_table = 3'(t);
        order_node  = 9'(pos);
        order_data  = d;
        @(posedge clk);
        #1;
        w = (ty == INS || ty == DEL) ? ((pos == 0) ? 0 : pos - 1) : pos;
        e.d   = ed;
        e.e   = ee;
        e.lat = ee ? 1 : w + 2;
        e.acc = cyc;
        sb.push_back(e);
        @(negedge clk);
        order_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((order_busy || sb.size() != 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) fail("idle_wait");
    endtask

    // Assert reset, check reset outputs, release and measure INIT length.
    task automatic do_reset();
        int   busy_cycles = 0;
        logic saw_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_order_busy", order_busy, 1);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_dout_data", dout_data, 0);
        check("rst_dout_err", dout_err, 0);
        check("rst_free_count", free_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        while (order_busy && busy_cycles < 1000) begin
            if (dout_valid) saw_valid = 1'b1;
            busy_cycles++;
            @(negedge clk);
        end
        check("init_busy_cycles", busy_cycles, 256);
        check("init_no_dout_valid", saw_valid, 0);
        check("init_free_count", free_count, 256);
        for (int t = 0; t < 8; t++) mq[t].delete();
    endtask

    // Monitor: compare each consumed response against the scoreboard head
    initial begin
        exp_t e;
        logic prev_v;
        int   rise;
        prev_v = 1'b0;
        rise   = 0;
        forever begin
            @(negedge clk);
            #1;
            if (dout_valid && !prev_v) rise = cyc;
            prev_v = dout_valid;
            if (dout_valid && !dout_busy) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_response: data %0d err %0d", dout_data, dout_err);
                end else begin
                    e = sb.pop_front();
                    check("resp_data", dout_data, e.d);
                    check("resp_err", dout_err, e.e);
                    check("resp_latency", rise - e.acc, e.lat);
                end
            end
        end
    end

    initial begin
        logic [15:0] hold_d;
        int          n;
        int          t;
        int          pos;
        logic [15:0] d;

        do_reset();

        // Basic insert ordering on table 3
        issue(INS, 3, 0, 16'd111, 16'd0, 1'b0);
        issue(INS, 3, 1, 16'd112, 16'd0, 1'b0);
        issue(INS, 3, 1, 16'd113, 16'd0, 1'b0);
        issue(RD, 3, 0, 16'd0, 16'd111, 1'b0);
        issue(RD, 3, 1, 16'd0, 16'd113, 1'b0);
        issue(RD, 3, 2, 16'd0, 16'd112, 1'b0);
        wait_idle();
        check("free_after_3_ins", free_count, 253);

        // Delete from the middle, then a read on an empty table
        issue(DEL, 3, 1, 16'd0, 16'd113, 1'b0);
        issue(RD, 3, 1, 16'd0, 16'd112, 1'b0);
        issue(RD, 5, 0, 16'd0, 16'd0, 1'b1);
        issue(RD, 3, 2, 16'd0, 16'd0, 1'b1);
        issue(INS, 3, 3, 16'd7, 16'd0, 1'b1);
        wait_idle();

        // Change with the sink stalled for 10 cycles
        dout_busy = 1'b1;
        issue(CHG, 3, 1, 16'hBEEF, 16'd112, 1'b0);
        n = 0;
        while (!dout_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!dout_valid) fail("stall_wait_valid");
        hold_d = dout_data;
        check("stall_first_data", hold_d, 112);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", dout_valid, 1);
            check("stall_data", dout_data, hold_d);
            check("stall_order_busy", order_busy, 1);
        end
        dout_busy = 1'b0;
        issue(RD, 3, 1, 16'd0, 16'hBEEF, 1'b0);
        wait_idle();
        check("free_after_change", free_count, 254);

        // Fill the whole pool across all tables from a clean state
        do_reset();
        for (int i = 0; i < 256; i++) begin
            t   = (i < 220) ? 0 : 1 + (i % 7);
            pos = (i % 5 == 0) ? mq[t].size() / 2 : 0;
            d   = 16'(i + 1000);
            issue(INS, t, pos, d, 16'd0, 1'b0);
            mq[t].insert(pos, d);
        end
        wait_idle();
        check("free_when_full", free_count, 0);
        issue(INS, 4, 0, 16'd9, 16'd0, 1'b1);
        issue(RD, 0, 200, 16'd0, mq[0][200], 1'b0);
        issue(RD, 7, 4, 16'd0, mq[7][4], 1'b0);

        // Drain every table from the head
        for (int tt = 0; tt < 8; tt++) begin
            while (mq[tt].size() != 0) begin
                issue(DEL, tt, 0, 16'd0, mq[tt][0], 1'b0);
                void'(mq[tt].pop_front());
            end
        end
        wait_idle();
        check("free_after_drain", free_count, 256);
        issue(INS, 2, 0, 16'h5555, 16'd0, 1'b0);
        issue(RD, 2, 0, 16'd0, 16'h5555, 1'b0);
        wait_idle();
        check("free_after_reinsert", free_count, 255);

        // Reset in the middle of a long walk
        for (int i = 0; i < 201; i++) issue(INS, 0, 0, 16'(i), 16'd0, 1'b0);
        issue(RD, 0, 200, 16'd0, 16'd0, 1'b0);
        repeat (50) @(negedge clk);
        check("walk_no_valid_yet", dout_valid, 0);
        do_reset();
        sb.delete();
        for (int tt = 0; tt < 8; tt++) issue(RD, tt, 0, 16'd0, 16'd0, 1'b1);
        wait_idle();
        check("free_after_midreset", free_count, 256);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
